// File: rtl/cc_pkg.sv
// -----------------------------------------------------------------------------
// cc_pkg
// Shared condition-code definitions for the ALU flag producer and its
// consumers (branch unit, future conditional-execute stage).
//   CC_N/CC_Z/CC_C/CC_V : bit positions of the flags inside a 4-bit cc word
//   cond_t              : 4-bit branch/execute condition encoding
//   cond_eval()         : pure evaluation of a condition against a flag word
// -----------------------------------------------------------------------------
package cc_pkg;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_C = 1;
    localparam int CC_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    function automatic logic cond_eval(input cond_t cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic taken;
        n     = f[CC_N];
        z     = f[CC_Z];
        c     = f[CC_C];
        v     = f[CC_V];
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = z || (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cc_cond_eval.sv
// -----------------------------------------------------------------------------
// cc_cond_eval
// Combinational condition evaluator: decides whether a 4-bit condition holds
// for a given {N,Z,C,V} flag word.
//   i_cond  : condition, cond_t encoding
//   i_flags : flags {N,Z,C,V}
//   o_taken : 1 when the condition is true
// -----------------------------------------------------------------------------
module cc_cond_eval
    import cc_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    assign o_taken = cond_eval(cond_t'(i_cond), i_flags);

endmodule

// File: rtl/cc_branch_unit.sv
// -----------------------------------------------------------------------------
// cc_branch_unit
// Owns the architectural {N,Z,C,V} flags register and resolves conditional
// branches into a registered redirect for the fetch stage.
//   clk, rst_n            : core clock, asynchronous active-low reset
//   alu_cc, cc_we         : ALU condition codes and their write enable
//   flags                 : current flags register
//   br_valid/br_ready     : branch request handshake
//   br_cond/pc/offset     : condition, branch PC, two's-complement displacement
//   rd_valid/rd_ready     : redirect handshake (one-entry output register)
//   rd_taken, rd_pc       : resolved direction and next PC
//   flush                 : kills the pending redirect and any same-cycle request
//   stat_br, stat_taken   : saturating accepted/taken branch counters
// -----------------------------------------------------------------------------
module cc_branch_unit
    import cc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           alu_cc,
    input  logic                 cc_we,
    output logic [3:0]           flags,
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [3:0]           br_cond,
    input  logic [WIDTH-1:0]     br_pc,
    input  logic [WIDTH-1:0]     br_offset,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 rd_taken,
    output logic [WIDTH-1:0]     rd_pc,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] stat_br,
    output logic [CNT_WIDTH-1:0] stat_taken
);

    localparam logic [WIDTH-1:0]     PC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]           r_flags;
    logic                 r_rd_valid;
    logic                 r_rd_taken;
    logic [WIDTH-1:0]     r_rd_pc;
    logic [CNT_WIDTH-1:0] r_stat_br;
    logic [CNT_WIDTH-1:0] r_stat_taken;

    logic [3:0]           w_eff_flags;
    logic                 w_taken;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_next_pc;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // A flag write in the same cycle is forwarded so a compare immediately
    // followed by a branch resolves against the new flags.
    assign w_eff_flags = cc_we ? alu_cc : r_flags;

    cc_cond_eval u_cond_eval (
        .i_cond  (br_cond),
        .i_flags (w_eff_flags),
        .o_taken (w_taken)
    );

    // Single output register: a new request fits only if the slot is empty
    // or is being drained this cycle.
    assign br_ready  = !r_rd_valid || rd_ready;
    assign w_accept  = br_valid && br_ready && !flush;

    // PC is word addressed; both paths wrap modulo 2^WIDTH.
    assign w_next_pc = w_taken ? (br_pc + br_offset) : (br_pc + PC_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags      <= 4'b0000;
            r_rd_valid   <= 1'b0;
            r_rd_taken   <= 1'b0;
            r_rd_pc      <= '0;
            r_stat_br    <= '0;
            r_stat_taken <= '0;
        end else begin
            // Flag writes proceed regardless of flush.
            if (cc_we) begin
                r_flags <= alu_cc;
            end

            if (flush) begin
                r_rd_valid <= 1'b0;
            end else if (w_accept) begin
                r_rd_valid <= 1'b1;
                r_rd_taken <= w_taken;
                r_rd_pc    <= w_next_pc;
                r_stat_br  <= sat_inc(r_stat_br);
                if (w_taken) begin
                    r_stat_taken <= sat_inc(r_stat_taken);
                end
            end else if (rd_ready) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign flags      = r_flags;
    assign rd_valid   = r_rd_valid;
    assign rd_taken   = r_rd_taken;
    assign rd_pc      = r_rd_pc;
    assign stat_br    = r_stat_br;
    assign stat_taken = r_stat_taken;

endmodule

// File: tb/tb_cc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_cc_branch_unit
// Scoreboard bench: the driver advances a behavioural model each clock and
// queues every expected redirect; a monitor pops and compares whenever the
// redirect handshake completes.
// -----------------------------------------------------------------------------
module tb_cc_branch_unit;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    alu_cc;
    logic          cc_we;
    logic [3:0]    flags;
    logic          br_valid;
    logic          br_ready;
    logic [3:0]    br_cond;
    logic [W-1:0]  br_pc;
    logic [W-1:0]  br_offset;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_taken;
    logic [W-1:0]  rd_pc;
    logic          flush;
    logic [CW-1:0] stat_br;
    logic [CW-1:0] stat_taken;

    cc_branch_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_cc     (alu_cc),
        .cc_we      (cc_we),
        .flags      (flags),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_cond    (br_cond),
        .br_pc      (br_pc),
        .br_offset  (br_offset),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_taken   (rd_taken),
        .rd_pc      (rd_pc),
        .flush      (flush),
        .stat_br    (stat_br),
        .stat_taken (stat_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         taken;
        logic [W-1:0] pc;
    } rd_t;

    rd_t        q[$];
    logic [3:0] m_flags;
    logic       m_valid;
    int         m_br;
    int         m_tk;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs: odd codes are the negation of
    // the even code below them (AL/NV included).
    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic model_edge(input logic v, input logic [3:0] cond, input logic [W-1:0] pc,
                              input logic [W-1:0] off, input logic rr, input logic we,
                              input logic [3:0] alu, input logic fl);
        logic         acc;
        logic [3:0]   eff;
        logic         t;
        logic [W-1:0] npc;
        acc = v && (!m_valid || rr) && !fl;
        eff = we ? alu : m_flags;
        if (fl && m_valid && !rr && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            t   = m_cond(cond, eff);
            npc = t ? pc + off : pc + 16'd1;
            q.push_back('{taken: t, pc: npc});
            if (m_br < SAT) m_br++;
            if (t && m_tk < SAT) m_tk++;
        end
        m_valid = fl ? 1'b0 : (acc ? 1'b1 : (rr ? 1'b0 : m_valid));
        if (we) m_flags = alu;
    endtask

    // Called just after a rising edge; applies inputs for one cycle.
    task automatic step(input logic v, input logic [3:0] cond, input logic [W-1:0] pc,
                        input logic [W-1:0] off, input logic rr, input logic we,
                        input logic [3:0] alu, input logic fl);
        br_valid = v; br_cond = cond; br_pc = pc; br_offset = off;
        rd_ready = rr; cc_we = we; alu_cc = alu; flush = fl;
        #1;
        check("br_ready", br_ready, !m_valid || rr);
        @(posedge clk);
        #1;
        model_edge(v, cond, pc, off, rr, we, alu, fl);
        check("flags", flags, m_flags);
        check("rd_valid", rd_valid, m_valid);
        check("stat_br", stat_br, m_br);
        check("stat_taken", stat_taken, m_tk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 4'd0, 16'h0, 16'h0, rr, 1'b0, 4'h0, 1'b0);
    endtask

    // Monitor: compares the presented redirect with the scoreboard head and
    // retires it when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rd_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got rd_valid=1 pc=%0h expected no redirect", rd_pc);
                end else begin
                    check("rd_taken", rd_taken, q[0].taken);
                    check("rd_pc", rd_pc, q[0].pc);
                    if (rd_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        br_valid = 1'b0; br_cond = 4'd0; br_pc = '0; br_offset = '0;
        rd_ready = 1'b0; cc_we = 1'b0; alu_cc = 4'h0; flush = 1'b0;
        m_flags = 4'h0; m_valid = 1'b0; m_br = 0; m_tk = 0;
        #12;
        check("rst_flags", flags, 4'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_taken", rd_taken, 1'b0);
        check("rst_rd_pc", rd_pc, 16'h0);
        check("rst_stats", {stat_br, stat_taken}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_br_ready", br_ready, 1'b1);

        // BEQ with Z clear: falls through to pc+1.
        step(1'b1, 4'd0, 16'h0010, 16'h0004, 1'b1, 1'b0, 4'h0, 1'b0);
        check("beq_nt_pc", rd_pc, 16'h0011);
        check("beq_nt_taken", rd_taken, 1'b0);

        // Same-cycle flag write forwarded into the branch.
        step(1'b1, 4'd0, 16'h0100, 16'hFFFE, 1'b1, 1'b1, 4'b0100, 1'b0);
        check("fwd_taken", rd_taken, 1'b1);
        check("fwd_pc", rd_pc, 16'h00FE);
        idle(1'b1);

        // Back-pressure: second request waits for the slot to drain.
        step(1'b1, 4'd14, 16'h0200, 16'h0005, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'd14, 16'h0300, 16'h0007, 1'b0, 1'b0, 4'h0, 1'b0);
        check("bp_held_pc", rd_pc, 16'h0205);
        step(1'b1, 4'd14, 16'h0300, 16'h0007, 1'b1, 1'b0, 4'h0, 1'b0);
        check("bp_next_pc", rd_pc, 16'h0307);
        idle(1'b1);

        // PC wrap on both paths.
        step(1'b1, 4'd15, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 4'h0, 1'b0);
        check("wrap_nt_pc", rd_pc, 16'h0000);
        step(1'b1, 4'd14, 16'hFFF0, 16'h0020, 1'b1, 1'b0, 4'h0, 1'b0);
        check("wrap_t_pc", rd_pc, 16'h0010);
        idle(1'b1);

        // Flush drops a same-cycle request, kills a pending one, keeps flag writes.
        step(1'b1, 4'd14, 16'h0400, 16'h0001, 1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 4'd14, 16'h0500, 16'h0001, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 4'd14, 16'h0600, 16'h0001, 1'b0, 1'b1, 4'b1001, 1'b1);
        idle(1'b1);

        // GE/LT spot checks, then exhaustive flags x condition sweep.
        step(1'b1, 4'd10, 16'h0020, 16'h0010, 1'b1, 1'b1, 4'b1001, 1'b0);
        check("ge_nv11", rd_taken, 1'b1);
        step(1'b1, 4'd11, 16'h0020, 16'h0010, 1'b1, 1'b1, 4'b1000, 1'b0);
        check("lt_nv10", rd_taken, 1'b1);
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 16; c++)
                step(1'b1, 4'(c), 16'($urandom), 16'($urandom), 1'b1, 1'b1, 4'(f), 1'b0);
        idle(1'b1);

        // Randomized traffic through the flags register path and back-pressure.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, 4'($urandom),
                 $urandom_range(0, 19) == 0);
        idle(1'b1);

        // Asynchronous reset between edges with a redirect stalled.
        step(1'b1, 4'd14, 16'h0700, 16'h0003, 1'b0, 1'b1, 4'hF, 1'b0);
        br_valid = 1'b0; cc_we = 1'b0; rd_ready = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_flags", flags, 4'h0);
        check("arst_rd_valid", rd_valid, 1'b0);
        check("arst_rd_taken", rd_taken, 1'b0);
        check("arst_rd_pc", rd_pc, 16'h0);
        check("arst_stat_br", stat_br, 4'h0);
        check("arst_stat_taken", stat_taken, 4'h0);
        q.delete();
        m_flags = 4'h0; m_valid = 1'b0; m_br = 0; m_tk = 0;
        #1 rst_n = 1'b1;

        // Saturation: 20 always-taken branches.
        for (int i = 0; i < 20; i++)
            step(1'b1, 4'd14, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 4'h0, 1'b0);
        check("sat_stat_br", stat_br, 4'hF);
        check("sat_stat_taken", stat_taken, 4'hF);
        idle(1'b1);
        idle(1'b1);
        check("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
